// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed memory responder with fixed access latency
// Self-initialising backing store; serialises one access at a time and keeps statistics.
module mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4,
  parameter int INIT_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_mem,
  input  logic        rd_mem,
  input  logic [31:0] addr_mem,
  input  logic [31:0] data_wr_mem,
  output logic [31:0] data_rd_mem,
  output logic        busy_mem,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] err_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACCESS} state_t;

  state_t          state_q;
  logic [AW-1:0]   init_idx_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            op_wr_q;
  logic [3:0]      cnt_q;
  logic            busy_q;
  logic [31:0]     rdata_q;
  logic [31:0]     rd_cnt_q;
  logic [31:0]     wr_cnt_q;
  logic [31:0]     err_cnt_q;

  logic [31:0]     mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [31:0]     mem_wdata;
  logic [AW-1:0]   req_idx;
  logic            acc_done;
  logic            unused_addr;

  assign req_idx     = addr_mem[AW+1:2];
  assign unused_addr = ^{addr_mem[31:AW+2], addr_mem[1:0]};
  assign acc_done    = (state_q == S_ACCESS) && (cnt_q == 4'(LATENCY));

  // Single write port shared by the init sweep and write completion; the states are exclusive.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = init_idx_q;
    mem_wdata = 32'({init_idx_q, 2'b00});
    if (!rst) begin
      if (state_q == S_INIT) begin
        mem_we = 1'b1;
      end else if (acc_done && op_wr_q) begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = wdata_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= (INIT_EN != 0) ? S_INIT : S_IDLE;
      init_idx_q <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      op_wr_q    <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b1;
      rdata_q    <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          busy_q     <= 1'b1;
          init_idx_q <= init_idx_q + 1'b1;
          if (init_idx_q == AW'(DEPTH - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_IDLE: begin
          busy_q <= 1'b0;
          if (rd_mem || wr_mem) begin
            idx_q   <= req_idx;
            wdata_q <= data_wr_mem;
            op_wr_q <= wr_mem;
            busy_q  <= 1'b1;
            cnt_q   <= 4'd1;
            state_q <= S_ACCESS;
            if (rd_mem && wr_mem) begin
              err_cnt_q <= err_cnt_q + 32'd1;
            end
          end
        end
        S_ACCESS: begin
          cnt_q <= cnt_q + 4'd1;
          if (acc_done) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
            if (op_wr_q) begin
              wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
              rdata_q  <= mem[idx_q];
              rd_cnt_q <= rd_cnt_q + 32'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_rd_mem = rdata_q;
  assign busy_mem    = busy_q;
  assign rd_count    = rd_cnt_q;
  assign wr_count    = wr_cnt_q;
  assign err_count   = err_cnt_q;

endmodule
